// File: rtl/chip_prog_pkg.sv
// Shared definitions for the serial programming link between the FPGA model
// and the chip-side receiver.
package chip_prog_pkg;

  localparam int FRAME_BITS = 5;
  localparam int HDR_BITS   = 2;
  localparam int GAIN_W     = FRAME_BITS - HDR_BITS;

  localparam logic [HDR_BITS-1:0] HDR_VAL = 2'b00;

  typedef enum logic [1:0] {
    sIDLE  = 2'd0,
    sSHIFT = 2'd1,
    sCHECK = 2'd2,
    sDONE  = 2'd3
  } state_t;

  function automatic logic hdr_ok(input logic [FRAME_BITS-1:0] frame);
    return frame[FRAME_BITS-1 -: HDR_BITS] == HDR_VAL;
  endfunction

endpackage

// File: rtl/chip_prog_rx_sync_edge_det.sv
// Multi-flop synchronizer with a registered level and a one-cycle rising-edge
// pulse aligned to that level.
module sync_edge_det #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [DEPTH-1:0] sync_r;
  logic             level_r;
  logic             rise_r;

  // Synchronizer chain, previous-level flop and edge pulse register
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r  <= {DEPTH{RST_VAL}};
      level_r <= RST_VAL;
      rise_r  <= 1'b0;
    end else begin
      sync_r  <= {sync_r[DEPTH-2:0], d};
      level_r <= sync_r[DEPTH-1];
      rise_r  <= sync_r[DEPTH-1] & ~level_r;
    end
  end

  assign level = level_r;
  assign rise  = rise_r;

endmodule

// File: rtl/chip_prog_rx.sv
// Chip-side receiver: oversamples sclk/sdin, shifts in one programming frame,
// checks its header and latches the amplifier gain.
module chip_prog_rx
  import chip_prog_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic              i_mainclk,
  input  logic              i_reset,
  input  logic              i_sclk,
  input  logic              i_sdin,
  output logic [GAIN_W-1:0] o_gainA1,
  output logic              o_ready,
  output logic              o_hdr_err
);

  localparam int BC_W = $clog2(FRAME_BITS + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [BC_W-1:0] BC_PENULT = BC_W'(FRAME_BITS - 1);
  localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT);

  state_t                  state_r, state_nx_s;
  logic                    rise_s, sdin_s;
  logic                    start_s, bit_s, last_s, abort_s;
  logic [FRAME_BITS-1:0]   shift_r;
  logic [BC_W-1:0]         bitcnt_r;
  logic [TO_W-1:0]         tocnt_r;
  logic [GAIN_W-1:0]       gain_r;
  logic                    ready_r, hdr_err_r;
  logic                    pend_r, pend_bit_r;

  sync_edge_det #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk   (i_mainclk),
    .reset (i_reset),
    .d     (i_sclk),
    .level (),
    .rise  (rise_s)
  );

  sync_edge_det #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sdin_sync (
    .clk   (i_mainclk),
    .reset (i_reset),
    .d     (i_sdin),
    .level (sdin_s),
    .rise  ()
  );

  // A rise caught during sCHECK is replayed as the first bit of the next frame
  assign start_s = rise_s | pend_r;
  assign bit_s   = pend_r ? pend_bit_r : sdin_s;
  assign last_s  = rise_s && (bitcnt_r == BC_PENULT);
  assign abort_s = !rise_s && (tocnt_r == TO_MAX);

  // State register
  always_ff @(posedge i_mainclk) begin
    if (i_reset) begin
      state_r <= sIDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      sIDLE, sDONE: begin
        if (start_s) begin
          state_nx_s = sSHIFT;
        end else begin
          state_nx_s = state_r;
        end
      end
      sSHIFT: begin
        if (last_s) begin
          state_nx_s = sCHECK;
        end else if (abort_s) begin
          state_nx_s = ready_r ? sDONE : sIDLE;
        end else begin
          state_nx_s = sSHIFT;
        end
      end
      sCHECK: begin
        if (hdr_ok(shift_r)) begin
          state_nx_s = sDONE;
        end else begin
          state_nx_s = sIDLE;
        end
      end
      default: state_nx_s = sIDLE;
    endcase
  end

  // Shift register, counters, pending edge and registered outputs
  always_ff @(posedge i_mainclk) begin
    if (i_reset) begin
      shift_r    <= '0;
      bitcnt_r   <= '0;
      tocnt_r    <= '0;
      gain_r     <= '0;
      ready_r    <= 1'b0;
      hdr_err_r  <= 1'b0;
      pend_r     <= 1'b0;
      pend_bit_r <= 1'b0;
    end else begin
      case (state_r)
        sIDLE, sDONE: begin
          if (start_s) begin
            shift_r  <= {{(FRAME_BITS-1){1'b0}}, bit_s};
            bitcnt_r <= BC_W'(1);
            tocnt_r  <= '0;
            pend_r   <= 1'b0;
          end
        end
        sSHIFT: begin
          if (rise_s) begin
            shift_r  <= {shift_r[FRAME_BITS-2:0], sdin_s};
            bitcnt_r <= bitcnt_r + BC_W'(1);
            tocnt_r  <= '0;
          end else if (abort_s) begin
            shift_r  <= '0;
            bitcnt_r <= '0;
            tocnt_r  <= '0;
          end else begin
            tocnt_r  <= tocnt_r + TO_W'(1);
          end
        end
        sCHECK: begin
          if (hdr_ok(shift_r)) begin
            gain_r    <= shift_r[GAIN_W-1:0];
            ready_r   <= 1'b1;
            hdr_err_r <= 1'b0;
          end else begin
            hdr_err_r <= 1'b1;
          end
          if (rise_s) begin
            pend_r     <= 1'b1;
            pend_bit_r <= sdin_s;
          end
        end
        default: begin
          shift_r  <= '0;
          bitcnt_r <= '0;
        end
      endcase
    end
  end

  assign o_gainA1  = gain_r;
  assign o_ready   = ready_r;
  assign o_hdr_err = hdr_err_r;

endmodule

// File: tb/tb_chip_prog_rx.sv
// Directed and randomized frames for chip_prog_rx, checked against a
// frame-level model of the gain/ready/header-error behaviour.
module tb_chip_prog_rx;
  import chip_prog_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sclk = 1'b1;
  logic              sdin = 1'b0;
  logic [GAIN_W-1:0] gain;
  logic              ready;
  logic              hdr_err;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] m_gain = 3'd0;
  logic       m_ready = 1'b0;
  logic       m_err = 1'b0;

  chip_prog_rx dut (
    .i_mainclk (clk),
    .i_reset   (rst),
    .i_sclk    (sclk),
    .i_sdin    (sdin),
    .o_gainA1  (gain),
    .o_ready   (ready),
    .o_hdr_err (hdr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".gain"}, 8'(gain), 8'(m_gain));
    check({tag, ".ready"}, 8'(ready), 8'(m_ready));
    check({tag, ".hdr_err"}, 8'(hdr_err), 8'(m_err));
  endtask

  task automatic check_idle_state(input string tag);
    logic [7:0] exp_state;
    exp_state = m_ready ? 8'(sDONE) : 8'(sIDLE);
    check({tag, ".state"}, 8'(dut.state_r), exp_state);
  endtask

  // Frame-level rule: zero header programs the gain, anything else flags an error
  task automatic model_frame(input logic [4:0] f);
    if (f[4:3] == 2'b00) begin
      m_gain  = f[2:0];
      m_ready = 1'b1;
      m_err   = 1'b0;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sclk = 1'b1;
    sdin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_gain = 3'd0;
    m_ready = 1'b0;
    m_err = 1'b0;
    check_outs("reset");
    check_idle_state("reset");
  endtask

  // Send the first n bits of f MSB first; a full frame is checked at P+1 and P+2
  task automatic send_bits(input logic [4:0] f, input int n, input int half, input bit full);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      sdin = f[4-i];
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      check("ready_hold", 8'(ready), 8'(m_ready));
      if (full && i == 4) begin
        repeat (4) @(negedge clk);
        check_outs("pre");
        model_frame(f);
        @(negedge clk);
        check_outs("post");
        repeat (half - 5) @(negedge clk);
      end else begin
        repeat (half) @(negedge clk);
      end
    end
  endtask

  task automatic do_timeout(input logic [4:0] f, input int n);
    send_bits(f, n, 16, 1'b0);
    repeat (70) @(negedge clk);
    check_outs("timeout");
    check_idle_state("timeout");
  endtask

  initial begin
    logic [4:0] f;
    int half;

    @(negedge clk);
    do_reset();

    send_bits(5'b00110, 5, 16, 1'b1);
    check("valid.gain", 8'(gain), 8'h06);

    do_reset();
    send_bits(5'b01101, 5, 16, 1'b1);
    check("badhdr.err", 8'(hdr_err), 8'h01);
    send_bits(5'b00101, 5, 16, 1'b1);
    check("goodhdr.gain", 8'(gain), 8'h05);

    do_timeout(5'b11111, 3);
    send_bits(5'b00011, 5, 16, 1'b1);
    check("after_to.gain", 8'(gain), 8'h03);

    send_bits(5'b00000, 2, 16, 1'b0);
    do_reset();
    send_bits(5'b00111, 5, 16, 1'b1);
    check("after_rst.gain", 8'(gain), 8'h07);

    send_bits(5'b00110, 5, 16, 1'b1);
    send_bits(5'b00010, 5, 16, 1'b1);
    check("reprog.gain", 8'(gain), 8'h02);

    for (int k = 0; k < 40; k++) begin
      f = 5'($urandom);
      if ($urandom_range(0, 9) < 7) f[4:3] = 2'b00;
      half = $urandom_range(16, 24);
      if ($urandom_range(0, 7) == 0) do_timeout(f, $urandom_range(1, 4));
      if ($urandom_range(0, 15) == 0) do_reset();
      send_bits(f, 5, half, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
